// File: rtl/alarm_pkg.sv
// Shared types and defaults for the alarm supervisory controller.
package alarm_pkg;

  typedef enum logic [2:0] {
    DISARMED = 3'd0,
    ARMING   = 3'd1,
    ARMED    = 3'd2,
    SIREN    = 3'd3,
    SILENCED = 3'd4
  } alarm_state_t;

  localparam int ARM_DELAY_DEF    = 4;
  localparam int SIREN_CYCLES_DEF = 8;
  localparam int CNT_W_DEF        = 4;

  // Bits needed to hold the larger of two terminal counts.
  function automatic int timer_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/alarm_timer.sv
// Loadable down-counter shared by the ARMING exit delay and the SIREN duration.
module alarm_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count;

  // Load has priority over counting; the counter parks at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm supervisory controller: arm/disarm, timed siren with acknowledge, event count.
// Optional siren strobing is built when ALARM_CTRL_STROBE_EN is defined.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int ARM_DELAY    = ARM_DELAY_DEF,
  parameter int SIREN_CYCLES = SIREN_CYCLES_DEF,
  parameter int CNT_W        = CNT_W_DEF
`ifdef ALARM_CTRL_STROBE_EN
  , parameter int STROBE_HALF = 2
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             arm,
  input  logic             disarm,
  input  logic             ack,
  input  logic             alarm_bit,
  output logic             det_clear,
  output logic             armed,
  output logic             siren,
  output logic             pending,
  output logic [CNT_W-1:0] event_count,
  output alarm_state_t     state_dbg
);

  localparam int TW = timer_width(ARM_DELAY, SIREN_CYCLES);
  localparam logic [TW-1:0] ARM_VAL   = TW'(ARM_DELAY - 1);
  localparam logic [TW-1:0] SIREN_VAL = TW'(SIREN_CYCLES - 1);

  alarm_state_t    state, next_state;
  logic            tmr_load, tmr_en, tmr_zero;
  logic [TW-1:0]   tmr_val;
  logic            cnt_inc;
  logic            siren_load;

  alarm_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= DISARMED;
    end else begin
      state <= next_state;
    end
  end

  // Priority inside each state: disarm > ack > alarm_bit > timer expiry.
  always_comb begin
    next_state = state;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    tmr_en     = 1'b0;
    cnt_inc    = 1'b0;
    case (state)
      DISARMED: begin
        if (!disarm && arm) begin
          next_state = ARMING;
          tmr_load   = 1'b1;
          tmr_val    = ARM_VAL;
        end
      end
      ARMING: begin
        if (disarm)        next_state = DISARMED;
        else if (tmr_zero) next_state = ARMED;
        else               tmr_en     = 1'b1;
      end
      ARMED: begin
        if (disarm) begin
          next_state = DISARMED;
        end else if (alarm_bit) begin
          next_state = SIREN;
          tmr_load   = 1'b1;
          tmr_val    = SIREN_VAL;
          cnt_inc    = 1'b1;
        end
      end
      SIREN: begin
        if (disarm) begin
          next_state = DISARMED;
        end else if (ack) begin
          next_state = ARMED;
        end else if (alarm_bit) begin
          tmr_load   = 1'b1;
          tmr_val    = SIREN_VAL;
          cnt_inc    = 1'b1;
        end else if (tmr_zero) begin
          next_state = SILENCED;
        end else begin
          tmr_en     = 1'b1;
        end
      end
      SILENCED: begin
        if (disarm) begin
          next_state = DISARMED;
        end else if (ack) begin
          next_state = ARMED;
        end else if (alarm_bit) begin
          next_state = SIREN;
          tmr_load   = 1'b1;
          tmr_val    = SIREN_VAL;
          cnt_inc    = 1'b1;
        end
      end
      default: next_state = DISARMED;
    endcase
  end

  // Entry into SIREN and retriggers both reload the timer.
  assign siren_load = tmr_load && (next_state == SIREN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      event_count <= '0;
    end else if (cnt_inc && (event_count != {CNT_W{1'b1}})) begin
      event_count <= event_count + 1'b1;
    end
  end

`ifdef ALARM_CTRL_STROBE_EN
  localparam int PW = timer_width(STROBE_HALF, 1);

  logic [PW-1:0] strobe_ph;
  logic          strobe;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      strobe    <= 1'b0;
      strobe_ph <= '0;
    end else if (siren_load) begin
      strobe    <= 1'b1;
      strobe_ph <= '0;
    end else if ((state == SIREN) && (next_state == SIREN)) begin
      if (strobe_ph == PW'(STROBE_HALF - 1)) begin
        strobe    <= ~strobe;
        strobe_ph <= '0;
      end else begin
        strobe_ph <= strobe_ph + 1'b1;
      end
    end else begin
      strobe    <= 1'b0;
      strobe_ph <= '0;
    end
  end

  assign siren = (state == SIREN) && strobe;
`else
  assign siren = (state == SIREN);
`endif

  assign det_clear = (state == DISARMED) || (state == ARMING);
  assign armed     = (state == ARMED) || (state == SIREN) || (state == SILENCED);
  assign pending   = (state == SIREN) || (state == SILENCED);
  assign state_dbg = state;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed self-checking bench for alarm_ctrl with a scoreboard of expected output vectors.
module tb_alarm_ctrl;
  import alarm_pkg::*;

  localparam int W = 11;

  logic clk, reset;
  logic arm, disarm, ack, alarm_bit;
  logic det_clear, armed, siren, pending;
  logic [3:0] event_count;
  alarm_state_t state_dbg;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           n_checks = 0;
  int           n_errors = 0;
  int           cnt_exp  = 0;

  alarm_ctrl #(.ARM_DELAY(4), .SIREN_CYCLES(8), .CNT_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .arm         (arm),
    .disarm      (disarm),
    .ack         (ack),
    .alarm_bit   (alarm_bit),
    .det_clear   (det_clear),
    .armed       (armed),
    .siren       (siren),
    .pending     (pending),
    .event_count (event_count),
    .state_dbg   (state_dbg)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Siren level expected on the i-th cycle since SIREN entry or retrigger.
  function automatic logic sir_on(input int i);
`ifdef ALARM_CTRL_STROBE_EN
    return ((i / 2) % 2) == 0;
`else
    return (i >= 0);
`endif
  endfunction

  function automatic logic [W-1:0] exp_v(input alarm_state_t s, input int c, input int i);
    logic dc, ar, si, pe;
    dc = (s == DISARMED) || (s == ARMING);
    ar = (s == ARMED) || (s == SIREN) || (s == SILENCED);
    si = (s == SIREN) && sir_on(i);
    pe = (s == SIREN) || (s == SILENCED);
    return {s, dc, ar, si, pe, c[3:0]};
  endfunction

  // scoreboard
  task automatic compare_head();
    logic [W-1:0] exp, obs;
    string        tag;
    exp = exp_q.pop_front();
    tag = tag_q.pop_front();
    obs = {state_dbg, det_clear, armed, siren, pending, event_count};
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step(input logic a, input logic d, input logic k, input logic ab,
                      input alarm_state_t s, input int i, input string tag);
    arm = a; disarm = d; ack = k; alarm_bit = ab;
    exp_q.push_back(exp_v(s, cnt_exp, i));
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    arm = 1'b0; disarm = 1'b0; ack = 1'b0; alarm_bit = 1'b0;
    compare_head();
  endtask

  task automatic check_now(input alarm_state_t s, input string tag);
    exp_q.push_back(exp_v(s, cnt_exp, 0));
    tag_q.push_back(tag);
    compare_head();
  endtask

  task automatic trigger(input alarm_state_t s, input string tag);
    if (cnt_exp < 15) cnt_exp++;
    step(0, 0, 0, 1, s, 0, tag);
  endtask

  task automatic arm_seq(input string tag);
    step(1, 0, 0, 0, ARMING, 0, tag);
    for (int j = 0; j < 3; j++) step(0, 0, 0, 0, ARMING, 0, tag);
    step(0, 0, 0, 0, ARMED, 0, tag);
  endtask

  initial begin
    reset = 1'b0; arm = 1'b0; disarm = 1'b0; ack = 1'b0; alarm_bit = 1'b0;
    #2;
    check_now(DISARMED, "reset_state");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // 1: arm with exit delay
    arm_seq("arm_delay");
    step(1, 0, 0, 0, ARMED, 0, "arm_ignored_armed");

    // 2: single trigger, timeout to SILENCED, ack
    trigger(SIREN, "siren_enter");
    for (int i = 1; i < 8; i++) step(0, 0, 0, 0, SIREN, i, "siren_hold");
    step(0, 0, 0, 0, SILENCED, 0, "silenced");
    step(0, 0, 0, 0, SILENCED, 0, "silenced_hold");
    step(0, 0, 1, 0, ARMED, 0, "ack_silenced");

    // 3: retrigger on the 5th siren cycle
    trigger(SIREN, "retrig_enter");
    for (int i = 1; i < 5; i++) step(0, 0, 0, 0, SIREN, i, "retrig_pre");
    trigger(SIREN, "retrig_reload");
    for (int i = 1; i < 8; i++) step(0, 0, 0, 0, SIREN, i, "retrig_post");
    step(0, 0, 0, 0, SILENCED, 0, "retrig_silenced");
    trigger(SIREN, "silenced_retrig");
    step(0, 0, 1, 0, ARMED, 0, "ack_siren");

    // 4: simultaneous inputs
    trigger(SIREN, "pre_disarm_ack");
    step(0, 1, 1, 0, DISARMED, 0, "disarm_ack_siren");
    step(1, 1, 0, 0, DISARMED, 0, "arm_disarm_dis");
    step(0, 0, 1, 1, DISARMED, 0, "ack_alarm_ignored_dis");
    arm_seq("rearm");
    trigger(SIREN, "pre_ack_alarm");
    step(0, 0, 1, 1, ARMED, 0, "ack_alarm_siren");

    // 5: saturation of the event count
    for (int t = 0; t < 20; t++) begin
      trigger(SIREN, "sat_trigger");
      step(0, 0, 1, 0, ARMED, 0, "sat_ack");
    end
    step(0, 1, 0, 0, DISARMED, 0, "disarm_keeps_count");

    // asynchronous reset mid-siren
    arm_seq("arm_for_reset");
    trigger(SIREN, "pre_reset");
    step(0, 0, 0, 0, SIREN, 1, "pre_reset_hold");
    reset = 1'b0;
    #1;
    cnt_exp = 0;
    check_now(DISARMED, "async_reset");
    step(1, 0, 0, 0, DISARMED, 0, "reset_held");
    reset = 1'b1;
    arm_seq("arm_after_reset");

    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: observed %0d left expected 0", exp_q.size());
    end

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alarm_ctrl.md
Name: alarm_ctrl

Overview:
- Supervisory controller for the lamp-sequence alarm detector: arms and disarms it, holds it cleared while unarmed, and turns its one-cycle alarm_bit indication into a timed siren with acknowledge.
- Also keeps a saturating alarm-event count.
- Sits between the operator panel inputs (arm/disarm/ack) and the detector plus siren driver.

Parameters:
- ARM_DELAY, 4: cycles spent in ARMING (exit delay) before detection is enabled; must be >= 1.
- SIREN_CYCLES, 8: cycles the siren sounds per trigger; must be >= 1.
- CNT_W, 4: width of event_count.
- STROBE_HALF, 2: siren strobe half-period in cycles; used only with ALARM_CTRL_STROBE_EN.

Ports:
- clk  input  1  system clock; all state is updated on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- arm  input  1  request to arm; sampled only in DISARMED.
- disarm  input  1  request to disarm; highest priority.
- ack  input  1  operator acknowledge of an alarm.
- alarm_bit  input  1  detection indication from the sequence detector.
- det_clear  output  1  holds the detector at IDLE (drives its reset) while 1.
- armed  output  1  1 in ARMED, SIREN, SILENCED.
- siren  output  1  siren drive.
- pending  output  1  alarm occurred and is not yet acknowledged (SIREN or SILENCED).
- event_count  output  CNT_W  number of triggers since reset; saturates at all-ones.

Behaviour:
- Moore outputs, decoded from registered state: a state change at edge k is visible right after edge k.
- Reset, asynchronous on reset==0: state=DISARMED, timer=0, event_count=0, det_clear=1, armed=0, siren=0, pending=0.
- Timer: loadable down-counter, width $clog2(max(ARM_DELAY,SIREN_CYCLES)+1).
- Input priority within a cycle: disarm > ack > alarm_bit > timer expiry.

States and transitions:
- DISARMED: det_clear=1.
  - arm=1 -> ARMING, timer loaded ARM_DELAY-1.
  - ack and alarm_bit are ignored.
- ARMING: det_clear=1.
  - disarm -> DISARMED.
  - timer==0 -> ARMED; otherwise the timer decrements.
  - Exactly ARM_DELAY cycles are spent in ARMING.
- ARMED: det_clear=0.
  - disarm -> DISARMED.
  - alarm_bit -> SIREN, timer loaded SIREN_CYCLES-1, event_count+1.
- SIREN: siren=1, pending=1, det_clear=0.
  - disarm -> DISARMED.
  - ack -> ARMED.
  - alarm_bit (retrigger) -> stay in SIREN, reload the timer, event_count+1.
  - timer==0 -> SILENCED; otherwise the timer decrements.
  - Exactly SIREN_CYCLES cycles are spent in SIREN with no retrigger.
- SILENCED: siren=0, pending=1.
  - disarm -> DISARMED.
  - ack -> ARMED.
  - alarm_bit -> SIREN with reload, event_count+1.

Boundary conditions:
- arm is ignored outside DISARMED.
- arm and disarm together in DISARMED: disarm wins, so the block stays DISARMED.
- ack and alarm_bit in the same cycle in SIREN: ack wins; the event is neither counted nor retriggered.
- event_count saturates at 2^CNT_W-1 and never wraps.
- event_count is cleared only by reset, not by disarm.
- Reset asserted mid-siren: siren drops immediately (asynchronous), without waiting for a clock edge.

Optional Feature:
- Macro: ALARM_CTRL_STROBE_EN.
- Defined:
  - siren = (state==SIREN) & strobe.
  - strobe is set to 1 on entry to SIREN or on a retrigger.
  - strobe toggles every STROBE_HALF cycles while in SIREN.
  - strobe is held 0 outside SIREN.
- Undefined: siren is steady 1 throughout SIREN, and no strobe logic is generated.

Decomposition:
- Package alarm_pkg:
  - state enum alarm_state_t {DISARMED, ARMING, ARMED, SIREN, SILENCED}, 3 bits.
  - default constants for ARM_DELAY, SIREN_CYCLES and CNT_W.
- One sub-module, alarm_timer: loadable down-counter with load, load value, enable and a zero flag. It is instantiated once and shared by ARMING and SIREN.

Test Plan (ARM_DELAY=4, SIREN_CYCLES=8, CNT_W=4):
1. Reset low mid-operation, then release; arm pulse -> det_clear=1 for 4 cycles of ARMING; then armed=1 and det_clear=0.
2. ARMED, alarm_bit pulse -> siren=1 for exactly 8 cycles, then SILENCED (siren=0, pending=1); event_count=1; ack -> ARMED, pending=0.
3. In SIREN at cycle 5, alarm_bit again -> siren lasts 8 more cycles (13 total); event_count=2.
4. Simultaneous cases:
   - disarm+ack in SIREN -> DISARMED, det_clear=1.
   - ack+alarm_bit in SIREN -> ARMED; event_count unchanged.
   - arm+disarm in DISARMED -> stays DISARMED.
5. 20 triggers with ack in between -> event_count holds at 15 and does not wrap; disarm leaves it at 15.
6. Strobe, with ALARM_CTRL_STROBE_EN defined and STROBE_HALF=2:
   - siren pattern during SIREN is 1,1,0,0,1,1,0,0.
   - with the macro undefined, siren is 8 consecutive 1s.
